// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit and its counter table.
package bru_pkg;

   typedef enum logic {
      BRU_RUN    = 1'b0,
      BRU_HALTED = 1'b1
   } bru_state_e;

   localparam logic [31:0] BRU_PC_INCR = 32'd4;

   // Reset value of each predictor counter: weakly not-taken.
   function automatic int unsigned bru_cnt_init(input int unsigned cnt_w);
      return (32'd1 << (cnt_w - 1)) - 32'd1;
   endfunction

endpackage

// File: rtl/bht_counter_table.sv
// Table of saturating prediction counters: one combinational read port,
// one saturating-update write port, synchronous reset of every entry.
module bht_counter_table
   import bru_pkg::*;
#(
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 2,
   parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(bru_cnt_init(CNT_W));

   logic [CNT_W-1:0] cnt_q [BHT_DEPTH];
   logic [CNT_W-1:0] cnt_d [BHT_DEPTH];

   assign rd_taken = cnt_q[rd_idx][CNT_W-1];

   always_comb begin
      cnt_d = cnt_q;
      if (wr_en) begin
         if (wr_taken && (cnt_q[wr_idx] != CNT_MAX)) begin
            cnt_d[wr_idx] = cnt_q[wr_idx] + 1'b1;
         end else if (!wr_taken && (cnt_q[wr_idx] != CNT_ZERO)) begin
            cnt_d[wr_idx] = cnt_q[wr_idx] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            cnt_q[i] <= CNT_INIT;
         end
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution with dynamic predictor, registered redirect and halt latch.
// Optional performance counters are built when BRU_PERF_EN is defined.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int PC_W      = 9,
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] f_pc,
   output logic            f_pred_taken,
   input  logic            ex_valid,
   input  logic [PC_W-1:0] ex_pc,
   input  logic [31:0]     ex_imm,
   input  logic            ex_jump,
   input  logic            ex_jumpreg,
   input  logic            ex_branch,
   input  logic            ex_halt,
   input  logic [31:0]     ex_alu_result,
   input  logic            ex_pred_taken,
   output logic [31:0]     pc_four,
   output logic            redirect,
   output logic [31:0]     redirect_pc,
   output logic            halted
`ifdef BRU_PERF_EN
   ,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   bru_state_e  state_q, state_d;
   logic        redirect_q, redirect_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic [31:0] ex_pc_ext, f_pc_ext, target;
   logic        taken, resolve, br_update, br_mispredict;
   logic        unused_pc_bits;

   assign ex_pc_ext = 32'(ex_pc);
   assign f_pc_ext  = 32'(f_pc);
   assign pc_four   = ex_pc_ext + BRU_PC_INCR;
   assign target    = ex_jumpreg ? (ex_alu_result & ~32'h1) : (ex_pc_ext + ex_imm);
   assign taken     = ex_jump | ex_jumpreg | (ex_branch & ex_alu_result[0]);

   // Only PC bits above the byte offset select a counter.
   assign unused_pc_bits = ^{f_pc_ext, ex_pc_ext};

   assign resolve       = ex_valid & (state_q == BRU_RUN);
   assign br_update     = resolve & ~ex_halt & ~ex_jump & ~ex_jumpreg & ex_branch;
   assign br_mispredict = br_update & (taken != ex_pred_taken);

   bht_counter_table #(
      .BHT_DEPTH (BHT_DEPTH),
      .CNT_W     (CNT_W),
      .IDX_W     (IDX_W)
   ) u_bht (
      .clk      (clk),
      .reset    (reset),
      .rd_idx   (f_pc_ext[IDX_W+1:2]),
      .rd_taken (f_pred_taken),
      .wr_en    (br_update),
      .wr_idx   (ex_pc_ext[IDX_W+1:2]),
      .wr_taken (taken)
   );

   always_comb begin
      state_d       = state_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      if (resolve) begin
         if (ex_halt) begin
            redirect_d    = 1'b1;
            redirect_pc_d = ex_pc_ext;
            state_d       = BRU_HALTED;
         end else if (ex_jump || ex_jumpreg) begin
            redirect_d    = 1'b1;
            redirect_pc_d = target;
         end else if (br_mispredict) begin
            redirect_d    = 1'b1;
            redirect_pc_d = taken ? target : pc_four;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= BRU_RUN;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign halted      = (state_q == BRU_HALTED);

`ifdef BRU_PERF_EN
   logic [31:0] perf_branches_q, perf_branches_d;
   logic [31:0] perf_mispredicts_q, perf_mispredicts_d;

   always_comb begin
      perf_branches_d    = perf_branches_q    + {31'd0, br_update};
      perf_mispredicts_d = perf_mispredicts_q + {31'd0, br_mispredict};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_branches_q    <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         perf_branches_q    <= perf_branches_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end

   assign perf_branches    = perf_branches_q;
   assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized
// resolutions checked against an arithmetic reference model of the predictor.
module tb_branch_resolve_unit;

   localparam int PC_W     = 9;
   localparam int DEPTH    = 16;
   localparam int CNT_MAX  = 3;
   localparam int CNT_HALF = 2;
   localparam int CNT_INIT = 1;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [PC_W-1:0] f_pc = '0;
   logic            f_pred_taken;
   logic            ex_valid = 1'b0;
   logic [PC_W-1:0] ex_pc = '0;
   logic [31:0]     ex_imm = '0;
   logic            ex_jump = 1'b0, ex_jumpreg = 1'b0, ex_branch = 1'b0, ex_halt = 1'b0;
   logic [31:0]     ex_alu_result = '0;
   logic            ex_pred_taken = 1'b0;
   logic [31:0]     pc_four;
   logic            redirect;
   logic [31:0]     redirect_pc;
   logic            halted;
`ifdef BRU_PERF_EN
   logic [31:0]     perf_branches, perf_mispredicts;
`endif

   branch_resolve_unit #(.PC_W(PC_W), .BHT_DEPTH(DEPTH), .CNT_W(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .f_pc          (f_pc),
      .f_pred_taken  (f_pred_taken),
      .ex_valid      (ex_valid),
      .ex_pc         (ex_pc),
      .ex_imm        (ex_imm),
      .ex_jump       (ex_jump),
      .ex_jumpreg    (ex_jumpreg),
      .ex_branch     (ex_branch),
      .ex_halt       (ex_halt),
      .ex_alu_result (ex_alu_result),
      .ex_pred_taken (ex_pred_taken),
      .pc_four       (pc_four),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .halted        (halted)
`ifdef BRU_PERF_EN
      ,
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          m_cnt [DEPTH];
   bit          m_halted;
   int unsigned m_br, m_mis;

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc / 4) % DEPTH);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      return m_cnt[m_idx(pc)] >= CNT_HALF;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < DEPTH; i++) m_cnt[i] = CNT_INIT;
      m_halted = 1'b0;
      m_br     = 0;
      m_mis    = 0;
   endtask

   // One cycle: drive a resolution, check combinational outputs, clock, check registered outputs.
   task automatic resolve(input string name, input bit valid, input logic [PC_W-1:0] pc,
                          input logic [31:0] imm, input bit jump, input bit jumpreg,
                          input bit branch, input bit halt, input logic [31:0] alu,
                          input bit pred, input logic [PC_W-1:0] fpc);
      logic [31:0] pce, exp_four, tgt, exp_rpc;
      bit          tk, exp_redir, exp_fpred, go_halt;
      int          k;
      ex_valid = valid; ex_pc = pc; ex_imm = imm; ex_jump = jump; ex_jumpreg = jumpreg;
      ex_branch = branch; ex_halt = halt; ex_alu_result = alu; ex_pred_taken = pred; f_pc = fpc;
      #1;
      pce      = 32'(pc);
      exp_four = pce + 32'd4;
      n_checks++;
      if (pc_four !== exp_four) begin
         n_fail++;
         $display("FAIL %s pc_four: got %h expected %h", name, pc_four, exp_four);
      end
      exp_fpred = m_pred(32'(fpc));
      n_checks++;
      if (f_pred_taken !== exp_fpred) begin
         n_fail++;
         $display("FAIL %s f_pred_taken(f_pc=%h): got %b expected %b", name, fpc, f_pred_taken, exp_fpred);
      end
      tgt       = jumpreg ? (alu & 32'hFFFF_FFFE) : (pce + imm);
      tk        = jump | jumpreg | (branch & alu[0]);
      exp_redir = 1'b0;
      exp_rpc   = '0;
      go_halt   = 1'b0;
      if (valid && !m_halted) begin
         if (halt) begin
            exp_redir = 1'b1; exp_rpc = pce; go_halt = 1'b1;
         end else if (jump || jumpreg) begin
            exp_redir = 1'b1; exp_rpc = tgt;
         end else if (branch) begin
            m_br++;
            if (tk != pred) begin
               m_mis++;
               exp_redir = 1'b1;
               exp_rpc   = tk ? tgt : exp_four;
            end
            k = m_idx(pce);
            if (tk) m_cnt[k] = (m_cnt[k] < CNT_MAX) ? m_cnt[k] + 1 : CNT_MAX;
            else    m_cnt[k] = (m_cnt[k] > 0) ? m_cnt[k] - 1 : 0;
         end
      end
      @(posedge clk);
      #1;
      if (go_halt) m_halted = 1'b1;
      n_checks++;
      if (redirect !== exp_redir) begin
         n_fail++;
         $display("FAIL %s redirect: got %b expected %b", name, redirect, exp_redir);
      end
      if (exp_redir) begin
         n_checks++;
         if (redirect_pc !== exp_rpc) begin
            n_fail++;
            $display("FAIL %s redirect_pc: got %h expected %h", name, redirect_pc, exp_rpc);
         end
      end
      n_checks++;
      if (halted !== m_halted) begin
         n_fail++;
         $display("FAIL %s halted: got %b expected %b", name, halted, m_halted);
      end
`ifdef BRU_PERF_EN
      n_checks++;
      if (perf_branches !== m_br || perf_mispredicts !== m_mis) begin
         n_fail++;
         $display("FAIL %s perf: got %0d/%0d expected %0d/%0d", name, perf_branches,
                  perf_mispredicts, m_br, m_mis);
      end
`endif
   endtask

   task automatic idle();
      ex_valid = 1'b0; ex_jump = 1'b0; ex_jumpreg = 1'b0; ex_branch = 1'b0; ex_halt = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      m_reset();
      n_checks++;
      if (redirect !== 1'b0 || redirect_pc !== 32'h0 || halted !== 1'b0) begin
         n_fail++;
         $display("FAIL reset outputs: got redirect=%b pc=%h halted=%b expected 0/0/0",
                  redirect, redirect_pc, halted);
      end
`ifdef BRU_PERF_EN
      n_checks++;
      if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0) begin
         n_fail++;
         $display("FAIL reset perf: got %0d/%0d expected 0/0", perf_branches, perf_mispredicts);
      end
`endif
      for (int i = 0; i < DEPTH; i++) begin
         f_pc = PC_W'(i * 4);
         #1;
         n_checks++;
         if (f_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset predict idx %0d: got %b expected 0", i, f_pred_taken);
         end
      end
   endtask

   task automatic test_predict_train();
      resolve("train1", 1, 9'h10, 32'h8, 0, 0, 1, 0, 32'h1, m_pred(32'h10), 9'h10);
      resolve("train2", 1, 9'h10, 32'h8, 0, 0, 1, 0, 32'h1, m_pred(32'h10), 9'h10);
      f_pc = 9'h10;
      idle();
      #1;
      n_checks++;
      if (f_pred_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL trained predict: got %b expected 1", f_pred_taken);
      end
   endtask

   task automatic test_taken_redirect();
      resolve("taken_back", 1, 9'h20, 32'hFFFF_FFF8, 0, 0, 1, 0, 32'h1, 0, 9'h20);
      n_checks++;
      if (redirect_pc !== 32'h18) begin
         n_fail++;
         $display("FAIL taken_back target: got %h expected 00000018", redirect_pc);
      end
      idle();
   endtask

   task automatic test_not_taken();
      resolve("nt_mispred", 1, 9'h40, 32'h100, 0, 0, 1, 0, 32'h0, 1, 9'h40);
      n_checks++;
      if (redirect_pc !== 32'h44) begin
         n_fail++;
         $display("FAIL nt_mispred fallthrough: got %h expected 00000044", redirect_pc);
      end
      resolve("nt_correct", 1, 9'h40, 32'h100, 0, 0, 1, 0, 32'h0, 0, 9'h40);
      idle();
   endtask

   task automatic test_jalr();
      resolve("jalr", 1, 9'h08, 32'h0, 0, 1, 0, 0, 32'h101, 0, 9'h08);
      n_checks++;
      if (redirect_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL jalr target: got %h expected 00000100", redirect_pc);
      end
      resolve("jal", 1, 9'h0C, 32'h40, 1, 0, 0, 0, 32'h0, 0, 9'h0C);
      idle();
   endtask

   task automatic test_halt();
      resolve("halt", 1, 9'h30, 32'h0, 0, 0, 0, 1, 32'h0, 0, 9'h70);
      n_checks++;
      if (redirect_pc !== 32'h30 || halted !== 1'b1) begin
         n_fail++;
         $display("FAIL halt: got pc=%h halted=%b expected 00000030/1", redirect_pc, halted);
      end
      resolve("halted_br", 1, 9'h70, 32'h10, 0, 0, 1, 0, 32'h1, 0, 9'h70);
      resolve("halted_jmp", 1, 9'h74, 32'h10, 1, 0, 0, 0, 32'h0, 0, 9'h70);
      idle();
      test_reset();
   endtask

   task automatic test_saturation();
      test_reset();
      for (int i = 0; i < 5; i++) begin
         resolve("sat_up", 1, 9'h50, 32'h20, 0, 0, 1, 0, 32'h1, m_pred(32'h50), 9'h50);
      end
      resolve("sat_down1", 1, 9'h50, 32'h20, 0, 0, 1, 0, 32'h0, m_pred(32'h50), 9'h50);
      idle();
      f_pc = 9'h50;
      #1;
      n_checks++;
      if (f_pred_taken !== 1'b1) begin
         n_fail++;
         $display("FAIL sat after one not-taken: got %b expected 1", f_pred_taken);
      end
`ifdef BRU_PERF_EN
      n_checks++;
      if (perf_branches !== 32'd6 || perf_mispredicts !== 32'd2) begin
         n_fail++;
         $display("FAIL sat perf: got %0d/%0d expected 6/2", perf_branches, perf_mispredicts);
      end
`endif
      resolve("sat_down2", 1, 9'h50, 32'h20, 0, 0, 1, 0, 32'h0, m_pred(32'h50), 9'h50);
      idle();
      #1;
      n_checks++;
      if (f_pred_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL sat after two not-taken: got %b expected 0", f_pred_taken);
      end
   endtask

   task automatic test_reset_mid();
      resolve("pre_reset", 1, 9'h60, 32'h40, 0, 0, 1, 0, 32'h1, 0, 9'h60);
      ex_valid = 1'b1; ex_pc = 9'h64; ex_branch = 1'b1; ex_alu_result = 32'h1;
      ex_pred_taken = 1'b0; reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      m_reset();
      n_checks++;
      if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid: got redirect=%b pc=%h expected 0/00000000", redirect, redirect_pc);
      end
      f_pc = 9'h64;
      #1;
      n_checks++;
      if (f_pred_taken !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid table: got %b expected 0", f_pred_taken);
      end
   endtask

   task automatic test_back_to_back();
      logic [PC_W-1:0] pc, fpc;
      logic [31:0]     imm, alu;
      int              kind, ioff;
      bit              pred;
      test_reset();
      for (int n = 0; n < 300; n++) begin
         pc   = PC_W'($urandom_range(0, 511));
         fpc  = ($urandom_range(0, 1) == 0) ? pc : PC_W'($urandom_range(0, 511));
         ioff = int'($urandom_range(0, 255)) - 128;
         imm  = 32'(ioff);
         alu  = $urandom;
         kind = int'($urandom_range(0, 9));
         pred = m_pred(32'(pc));
         if ($urandom_range(0, 3) == 0) pred = ~pred;
         case (kind)
            0:       resolve("rand_jal", 1, pc, imm, 1, 0, 0, 0, alu, pred, fpc);
            1:       resolve("rand_jalr", 1, pc, imm, 0, 1, 0, 0, alu, pred, fpc);
            9:       resolve("rand_none", $urandom_range(0, 1) == 1, pc, imm, 0, 0, 0, 0, alu, pred, fpc);
            default: resolve("rand_br", $urandom_range(0, 7) != 0, pc, imm, 0, 0, 1, 0, alu, pred, fpc);
         endcase
      end
      idle();
   endtask

   initial begin
      m_reset();
      test_reset();
      test_predict_train();
      test_taken_redirect();
      test_not_taken();
      test_jalr();
      test_halt();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised execute-stage branch resolution unit with a dynamic predictor. It resolves jumps, indirect jumps, conditional branches and halt, and keeps a table of saturating counters that fetch reads to predict conditional branches. On a misprediction it issues a registered, one-cycle redirect to the PC mux and flush logic, and it latches halt until reset.

## Interface
- `PC_W`, 9: width of PC inputs; zero-extended to 32 bits internally.
- `BHT_DEPTH`, 16: number of counter entries; power of two, ≥ 2.
- `CNT_W`, 2: counter width, ≥ 1.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `f_pc`  in  PC_W  fetch PC used for lookup.
- `f_pred_taken`  out  1  prediction for `f_pc`. Combinational read of registered table.
- `ex_valid`  in  1  an execute-stage instruction resolves this cycle.
- `ex_pc`  in  PC_W  PC of the resolving instruction.
- `ex_imm`  in  32  sign-extended immediate.
- `ex_jump`, `ex_jumpreg`, `ex_branch`, `ex_halt`  in  1 each  decode class flags.
- `ex_alu_result`  in  32  jalr target, or branch condition in bit 0 (1 = taken).
- `ex_pred_taken`  in  1  prediction carried down the pipe with the instruction.
- `pc_four`  out  32  `{0, ex_pc} + 4`, combinational.
- `redirect`  out  1  registered one-cycle redirect/flush pulse.
- `redirect_pc`  out  32  registered redirect target; valid when `redirect` = 1.
- `halted`  out  1  high from the cycle after a halt resolves until reset.
- `perf_branches`, `perf_mispredicts`  out  32 each  present only with `BRU_PERF_EN`.

## Operation
- Index `idx = ex_pc[IDX_W+1:2]` (resp. `f_pc`), with `IDX_W = $clog2(BHT_DEPTH)`.
- Prediction is the MSB of counter `idx`.
- Target:
  - `ex_jumpreg`: `ex_alu_result & ~32'h1`.
  - Otherwise: `{0, ex_pc} + ex_imm`, modulo 2^32.
- `taken = ex_jump | ex_jumpreg | (ex_branch & ex_alu_result[0])`.
- Resolution applies only when `ex_valid` is high and the unit is in RUN. Priority is halt > jump/jumpreg > branch:
  - **halt:** redirect to `{0, ex_pc}` (PC spins); go to HALTED.
  - **jump/jumpreg:** always redirect to target. The predictor does not predict jumps.
  - **branch, `taken != ex_pred_taken`:** redirect to target if `taken`, else `pc_four`.
  - **branch, correctly predicted:** no redirect.
  - **none of the above:** no action.
- Counter update happens only for a conditional branch in RUN:
  - Saturating increment if taken, saturating decrement if not taken.
  - Saturation points are 0 and `2^CNT_W − 1`.
  - Jumps and halts do not touch the table.
- FSM with two states:
  - RUN → HALTED on a resolved halt.
  - HALTED → RUN only on `reset`.
  - In HALTED, `ex_valid` is ignored: no redirect, no counter update, no perf count.

## Timing
- On reset:
  - `redirect` = 0, `redirect_pc` = 0, `halted` = 0, state RUN.
  - All counters = `2^(CNT_W−1) − 1` (weakly not-taken).
  - Perf counters = 0.
- Reset mid-operation discards any pending redirect. Reset wins over a simultaneous `ex_valid`.
- Latency: resolution in cycle N gives `redirect`/`redirect_pc` in cycle N+1. `redirect` is a single-cycle pulse.
- Back-to-back resolutions are accepted every cycle. The upstream flush must kill the younger one; the unit does not filter it.
- Counter write lands at the clock edge. A same-cycle `f_pc` read of the same index returns the old value.
- `halted` rises in cycle N+1, together with the halt redirect pulse.
- `pc_four` and `f_pred_taken` are combinational with no added latency.

## Configuration
- `BRU_PERF_EN` defined:
  - `perf_branches` counts resolved conditional branches in RUN.
  - `perf_mispredicts` counts those with `taken != ex_pred_taken`.
  - Both are 32-bit wrapping counters, zeroed by reset.
- `BRU_PERF_EN` undefined: both ports and their counters are absent.

## Structure
- Package `bru_pkg` holds:
  - state enum `bru_state_e` (`BRU_RUN`, `BRU_HALTED`);
  - constant `BRU_PC_INCR = 32'd4`;
  - function `bru_cnt_init(cnt_w)`.
- Sub-module `bht_counter_table`:
  - parameters `BHT_DEPTH`, `CNT_W`;
  - one combinational read port, one saturating-update write port;
  - synchronous reset of every entry.
- The top level holds target arithmetic, the FSM, redirect registers and the perf counters.

## Test plan
- Defaults; reset; `f_pc` = 0x10 → `f_pred_taken` = 0. Branch at 0x10 taken twice → `f_pred_taken` = 1 after the second update.
- Branch at `ex_pc` = 0x20, `ex_imm` = −8, taken, `ex_pred_taken` = 0 → next cycle `redirect` = 1, `redirect_pc` = 0x18.
- Branch at 0x40, not taken, `ex_pred_taken` = 1 → `redirect_pc` = 0x44. The same branch correctly predicted → no redirect.
- jalr with `ex_alu_result` = 0x101 → `redirect_pc` = 0x100.
- Halt at 0x30 → `redirect_pc` = 0x30, `halted` = 1. A following branch with `ex_valid` → no redirect, table unchanged. `reset` → `halted` = 0.
- Counter saturation: 5 taken updates on one index (CNT_W = 2) → counter = 3. One not-taken → 2, prediction still taken. With `BRU_PERF_EN`, check `perf_branches` = 6 and the mispredict count.
